// File: rtl/pixel_scanout.sv
// pixel_scanout: plot-port framebuffer writer plus 640x480@60 VGA scan-out.
// The framebuffer is FB_W x FB_H with 9-bit RGB333 pixels. Each source pixel
// is shown as a 2x2 block on the 640x480 raster.
//
// Ports
//   clk, resetn             50 MHz clock, async active-low reset
//   x, y, colour, plot      plot request, one pixel per cycle with plot high
//   fb_waddr/wdata/wren     registered framebuffer write, 1 clk after plot
//   fb_raddr, fb_rdata      scan-out read; rdata is valid one clk after raddr
//   VGA_R/G/B               8-bit DAC colour, zero while blanked
//   VGA_HS/VS               active-low syncs
//   VGA_BLANK_N, VGA_SYNC_N, VGA_CLK   DAC control (SYNC_N tied low)
//
// Optional feature: define WRITE_BOUNDS_CHECK_EN to drop plots that fall
// outside the framebuffer. Without it every plot is written and the address
// wraps at 17 bits.

module pixel_scanout_lane (
  input  logic       clk,
  input  logic       resetn,
  input  logic       vis,
  input  logic [2:0] c,
  output logic [7:0] q
);
  // Replicating the 3-bit code fills the 8-bit range: 0 -> 00, 7 -> FF.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) q <= '0;
    else         q <= vis ? {c, c, c[2:1]} : 8'h00;
endmodule

module pixel_scanout #(
  parameter int FB_W = 320,
  parameter int FB_H = 240
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  input  logic [8:0]  colour,
  input  logic        plot,
  output logic [16:0] fb_waddr,
  output logic [8:0]  fb_wdata,
  output logic        fb_wren,
  output logic [16:0] fb_raddr,
  input  logic [8:0]  fb_rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK
);
  localparam int NUM_LANES = 3;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_SS   = 10'd656;
  localparam logic [9:0] H_SE   = 10'd752;
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_SS   = 10'd490;
  localparam logic [9:0] V_SE   = 10'd492;
  localparam logic [9:0] V_LAST = 10'd524;

  typedef struct packed {
    logic [16:0] addr;
    logic [8:0]  data;
  } wr_req_t;

  // ---------------- write path ----------------
  wr_req_t wr_c, wr_q;
  logic    wr_ok;

  always_comb begin
    wr_c.addr = 17'(y) * 17'(FB_W) + 17'(x);
    wr_c.data = colour;
  end

`ifdef WRITE_BOUNDS_CHECK_EN
  assign wr_ok = (32'(x) < FB_W) && (32'(y) < FB_H);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fb_wren <= 1'b0;
      wr_q    <= '0;
    end else begin
      fb_wren <= plot & wr_ok;
      if (plot && wr_ok) wr_q <= wr_c;
    end

  assign fb_waddr = wr_q.addr;
  assign fb_wdata = wr_q.data;

  // ---------------- raster counters ----------------
  logic       pix_en;
  logic [9:0] hcnt, vcnt;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pix_en <= 1'b0;
      hcnt   <= '0;
      vcnt   <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end

  // ---------------- scan-out ----------------
  // Stage 0 is the counters (read address issued combinationally), stage 1
  // lines up with fb_rdata, stage 2 is the pins.
  logic       vis_c, hs_c, vs_c;
  logic [2:1] vld_pipe, hs_pipe, vs_pipe;

  always_comb begin
    vis_c    = (hcnt < H_VIS) && (vcnt < V_VIS);
    hs_c     = !((hcnt >= H_SS) && (hcnt < H_SE));
    vs_c     = !((vcnt >= V_SS) && (vcnt < V_SE));
    fb_raddr = '0;
    // Counter LSBs are dropped so each source pixel covers 2x2 raster pixels.
    if (vis_c && (32'(vcnt[9:1]) < FB_H) && (32'(hcnt[9:1]) < FB_W))
      fb_raddr = 17'(vcnt[9:1]) * 17'(FB_W) + 17'(hcnt[9:1]);
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      vld_pipe <= {vld_pipe[1], vis_c};
      hs_pipe  <= {hs_pipe[1], hs_c};
      vs_pipe  <= {vs_pipe[1], vs_c};
    end

  logic [NUM_LANES-1:0][2:0] lane_c;
  logic [NUM_LANES-1:0][7:0] lane_q;

  assign lane_c = fb_rdata;   // lane 2 = R, 1 = G, 0 = B

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      pixel_scanout_lane u_lane (
        .clk    (clk),
        .resetn (resetn),
        .vis    (vld_pipe[1]),
        .c      (lane_c[i]),
        .q      (lane_q[i])
      );
    end
  endgenerate

  assign VGA_R       = lane_q[2];
  assign VGA_G       = lane_q[1];
  assign VGA_B       = lane_q[0];
  assign VGA_HS      = hs_pipe[2];
  assign VGA_VS      = vs_pipe[2];
  assign VGA_BLANK_N = vld_pipe[2];
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en;

endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout: write-path scoreboard plus a per-cycle raster model
// of the scan-out pins, reset-state checks and a mid-write reset.
module tb_pixel_scanout;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  x = '0, y = '0, colour = '0;
  logic        plot = 1'b0;
  logic [16:0] fb_waddr, fb_raddr;
  logic [8:0]  fb_wdata;
  logic        fb_wren;
  logic [8:0]  fb_rdata = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

  pixel_scanout dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_wren(fb_wren),
    .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
  );

  always #10 clk = ~clk;

  function automatic logic [8:0] ram_f(input logic [16:0] a);
    return (a == 17'd0) ? 9'h1FF : (a[8:0] ^ 9'h0A5);
  endfunction

  function automatic logic [7:0] ex(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // synchronous-read RAM model
  always @(posedge clk) fb_rdata <= ram_f(fb_raddr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // edges since reset release
  int k = 0;
  always @(posedge clk or negedge resetn)
    if (!resetn) k <= 0;
    else         k <= k + 1;

  typedef struct {
    int          c;
    logic [16:0] a;
    logic [8:0]  d;
  } exp_t;
  exp_t sb[$];

  bit chk_rst = 1'b0;
  bit done    = 1'b0;

  localparam logic [72:0] RST_EXP =
    {1'b0, 17'd0, 9'd0, 17'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  int nvec = 0, nerr = 0, hs_low = 0;
  int pq, ph, pv, pa, cq, ch, cv, ca;
  bit pvis, cvis;
  logic [8:0]  pd;
  logic [72:0] got;
  logic [45:0] sgot, swant;
  exp_t e;

  always @(negedge clk) begin
    if (!resetn) begin
      hs_low = 0;
      if (chk_rst) begin
        nvec++;
        got = {fb_wren, fb_waddr, fb_wdata, fb_raddr, VGA_R, VGA_G, VGA_B,
               VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK};
        if (got !== RST_EXP) begin
          nerr++;
          $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc, got, RST_EXP);
        end
      end
    end else begin
      if (fb_wren) begin
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL write_unexpected cyc=%0d addr=%0d data=%h want no write",
                   cyc, fb_waddr, fb_wdata);
        end else begin
          e = sb.pop_front();
          if (e.c != cyc || e.a !== fb_waddr || e.d !== fb_wdata) begin
            nerr++;
            $display("FAIL write cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                     cyc, fb_waddr, fb_wdata, e.c, e.a, e.d);
          end
        end
      end
      if (k >= 2) begin
        // pins show the raster position two edges ago
        pq = (k - 2) / 2; ph = pq % 800; pv = (pq / 800) % 525;
        pvis = (ph < 640) && (pv < 480);
        pa = pvis ? (pv / 2) * 320 + ph / 2 : 0;
        pd = ram_f(17'(pa));
        cq = k / 2; ch = cq % 800; cv = (cq / 800) % 525;
        cvis = (ch < 640) && (cv < 480);
        ca = cvis ? (cv / 2) * 320 + ch / 2 : 0;
        swant = {pvis ? ex(pd[8:6]) : 8'h00, pvis ? ex(pd[5:3]) : 8'h00,
                 pvis ? ex(pd[2:0]) : 8'h00,
                 !(ph >= 656 && ph < 752), !(pv >= 490 && pv < 492), pvis,
                 1'b0, (k % 2) == 1, 17'(ca)};
        sgot = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                VGA_CLK, fb_raddr};
        nvec++;
        if (sgot !== swant) begin
          nerr++;
          $display("FAIL scan k=%0d h=%0d v=%0d got=%h want=%h", k, ph, pv, sgot, swant);
        end
        if (k <= 1601 && VGA_HS === 1'b0) hs_low++;
        if (k == 1602) begin
          nvec++;
          if (hs_low != 192) begin
            nerr++;
            $display("FAIL hs_low_clks got=%0d want=192", hs_low);
          end
        end
      end
    end
    if (done) begin
      nvec++;
      if (sb.size() != 0) begin
        nerr++;
        $display("FAIL writes_missing got=%0d pending want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
    end
  end

  task automatic idle(input int n);
    plot = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] px, input logic [8:0] py,
                    input logic [8:0] pc, input bit ew, input logic [16:0] ea);
    x = px; y = py; colour = pc; plot = 1'b1;
    if (ew) sb.push_back('{cyc + 1, ea, pc});
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_rst = 1'b0;
    resetn  = 1'b1;
    idle(4);
    wr(9'd5, 9'd2, 9'h1C0, 1'b1, 17'd645);
    idle(3);
    wr(9'd0, 9'd0, 9'h007, 1'b1, 17'd0);
    wr(9'd1, 9'd0, 9'h038, 1'b1, 17'd1);
    wr(9'd2, 9'd0, 9'h1C0, 1'b1, 17'd2);
    wr(9'd3, 9'd0, 9'h155, 1'b1, 17'd3);
    idle(3);
    wr(9'd319, 9'd239, 9'h0AA, 1'b1, 17'd76799);
    idle(2);
`ifdef WRITE_BOUNDS_CHECK_EN
    wr(9'd320, 9'd0, 9'h1FF, 1'b0, 17'd0);
    idle(2);
    wr(9'd0, 9'd240, 9'h123, 1'b0, 17'd0);
    idle(2);
    wr(9'd511, 9'd511, 9'h0F0, 1'b0, 17'd0);
    idle(2);
`else
    wr(9'd320, 9'd0, 9'h1FF, 1'b1, 17'd320);
    idle(2);
    wr(9'd0, 9'd240, 9'h123, 1'b1, 17'd76800);
    idle(2);
    wr(9'd511, 9'd511, 9'h0F0, 1'b1, 17'd32959);
    idle(2);
`endif
    // reach hcnt=300, vcnt=2 (edge 3800 since release)
    while (k < 3800) begin
      @(posedge clk);
      #1;
    end
    x = 9'd7; y = 9'd7; colour = 9'h1A5; plot = 1'b1;
    @(posedge clk);
    #1;
    // write now in flight; reset must kill it without waiting for a clock
    resetn  = 1'b0;
    chk_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    plot    = 1'b0;
    chk_rst = 1'b0;
    resetn  = 1'b1;
    idle(200);
    wr(9'd1, 9'd1, 9'h0C3, 1'b1, 17'd321);
    idle(4);
    done = 1'b1;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1);
  end
endmodule
